// File: rtl/arb_pkg.sv
// Shared definitions for the three-requester round-robin arbiter family.
//   arb_state_t : arbiter FSM encoding (IDLE, GRANT, GAP)
//   REQ_*       : fixed requester indices (UART debug, instruction fetch, data cache)
//   rr_next     : mod-3 successor of a requester index
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_UART   = 2'd0;
    localparam logic [1:0] REQ_IFETCH = 2'd1;
    localparam logic [1:0] REQ_DCACHE = 2'd2;

    // Index 3 is not a legal requester; folding it onto 0 keeps every
    // derived index inside [0,2] so it can safely index a 3-bit vector.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports:
//   req    [2:0] in  : request vector
//   last   [1:0] in  : index of the previous winner
//   win    [2:0] out : one-hot winner (all zero when no request)
//   win_id [1:0] out : index of the winner (0 when no request)
// Search order is last+1, last+2, last (mod 3).
module rr_pick3
    import arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] win,
    output logic [1:0] win_id
);

    logic [1:0] cand [3];

    always_comb begin
        cand[0] = rr_next(last);
        cand[1] = rr_next(cand[0]);
        cand[2] = rr_next(cand[1]);
    end

    always_comb begin
        win_id = 2'd0;
        win    = 3'b000;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int i = 2; i >= 0; i--) begin
            if (req[cand[i]]) begin
                win_id = cand[i];
            end
        end
        if (|req) begin
            win = 3'b001 << win_id;
        end
    end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with hold-until-finish grants and a
// grant watchdog. All outputs are registered.
// Parameters:
//   TIMEOUT : watchdog limit in grant cycles, 0 disables the watchdog
//   TO_W    : watchdog counter width (TIMEOUT < 2**TO_W)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req0/req1/req2  in   : requests, held until the matching grant is seen
//   finish          in   : one-cycle completion pulse from the channel manager
//   clr_err         in   : clears to_sticky
//   gnt0/gnt1/gnt2  out  : grants, at most one high
//   sel[2:0]        out  : one-hot channel owner, keeps last winner after release
//   busy            out  : grant outstanding
//   timeout         out  : one-cycle pulse on watchdog release
//   to_sticky       out  : latched timeout flag
//   to_id[1:0]      out  : requester released by the last timeout
module rr_arbiter3
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       finish,
    input  logic       clr_err,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout,
    output logic       to_sticky,
    output logic [1:0] to_id
);

    localparam logic [TO_W-1:0] TO_LIM = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    arb_state_t      state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            sticky_q, sticky_d;
    logic [1:0]      to_id_q, to_id_d;

    logic [2:0]      req_vec;
    logic [2:0]      win;
    logic [1:0]      win_id;
    logic            wd_hit;

    assign req_vec = {req2, req1, req0};

    rr_pick3 u_pick (
        .req    (req_vec),
        .last   (last_q),
        .win    (win),
        .win_id (win_id)
    );

    // Counter value TIMEOUT-1 marks the last allowed grant cycle.
    assign wd_hit = (TIMEOUT != 0) && (cnt_q == TO_LIM);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        to_id_d   = to_id_q;
        // A timeout raised below overrides this clear.
        sticky_d  = sticky_q & ~clr_err;

        unique case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    last_d  = win_id;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (finish || wd_hit) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                    // finish wins a tie with expiry: no timeout reported.
                    if (!finish) begin
                        timeout_d = 1'b1;
                        sticky_d  = 1'b1;
                        to_id_d   = last_q;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + TO_ONE;
                end
            end
            GAP: begin
                // One dead cycle lets the released requester drop its req.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= REQ_DCACHE;
            gnt_q     <= 3'b000;
            sel_q     <= 3'b000;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            sticky_q  <= 1'b0;
            to_id_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            sticky_q  <= sticky_d;
            to_id_q   <= to_id_d;
        end
    end

    assign gnt0      = gnt_q[REQ_UART];
    assign gnt1      = gnt_q[REQ_IFETCH];
    assign gnt2      = gnt_q[REQ_DCACHE];
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign to_sticky = sticky_q;
    assign to_id     = to_id_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed bench for rr_arbiter3: one instance with an 8-cycle watchdog and
// one with the watchdog disabled, both driven by the same stimulus.
module tb_rr_arbiter3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       fin;
    logic       clr;

    logic       wd_g0, wd_g1, wd_g2, wd_busy, wd_to, wd_sticky;
    logic [2:0] wd_sel;
    logic [1:0] wd_id;
    logic       nw_g0, nw_g1, nw_g2, nw_busy, nw_to, nw_sticky;
    logic [2:0] nw_sel;
    logic [1:0] nw_id;

    logic [2:0] wd_gnt, nw_gnt;
    assign wd_gnt = {wd_g2, wd_g1, wd_g0};
    assign nw_gnt = {nw_g2, nw_g1, nw_g0};

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter3 #(.TIMEOUT(8), .TO_W(16)) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req[0]),
        .req1      (req[1]),
        .req2      (req[2]),
        .finish    (fin),
        .clr_err   (clr),
        .gnt0      (wd_g0),
        .gnt1      (wd_g1),
        .gnt2      (wd_g2),
        .sel       (wd_sel),
        .busy      (wd_busy),
        .timeout   (wd_to),
        .to_sticky (wd_sticky),
        .to_id     (wd_id)
    );

    rr_arbiter3 #(.TIMEOUT(0), .TO_W(16)) u_nw (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req[0]),
        .req1      (req[1]),
        .req2      (req[2]),
        .finish    (fin),
        .clr_err   (clr),
        .gnt0      (nw_g0),
        .gnt1      (nw_g1),
        .gnt2      (nw_g2),
        .sel       (nw_sel),
        .busy      (nw_busy),
        .timeout   (nw_to),
        .to_sticky (nw_sticky),
        .to_id     (nw_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [2:0] alt_exp [4] = '{3'b100, 3'b001, 3'b100, 3'b001};

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        fin   = 1'b0;
        clr   = 1'b0;
        step();
        step();
        check_eq("rst_gnt",    32'(wd_gnt),    32'h0);
        check_eq("rst_sel",    32'(wd_sel),    32'h0);
        check_eq("rst_busy",   32'(wd_busy),   32'h0);
        check_eq("rst_to",     32'(wd_to),     32'h0);
        check_eq("rst_sticky", 32'(wd_sticky), 32'h0);
        check_eq("rst_to_id",  32'(wd_id),     32'h0);
        rst_n = 1'b1;
        step();
        check_eq("idle_noreq_gnt", 32'(wd_gnt), 32'h0);

        // All three request together: order 0, 1, 2.
        req = 3'b111;
        step();
        check_eq("s1_gnt0",  32'(wd_gnt),  32'h1);
        check_eq("s1_sel0",  32'(wd_sel),  32'h1);
        check_eq("s1_busy0", 32'(wd_busy), 32'h1);
        req = 3'b110;
        fin = 1'b1;
        step();
        fin = 1'b0;
        check_eq("s1_rel_gnt",  32'(wd_gnt),  32'h0);
        check_eq("s1_rel_busy", 32'(wd_busy), 32'h0);
        check_eq("s1_rel_sel",  32'(wd_sel),  32'h1);
        step();
        check_eq("s1_gap_gnt", 32'(wd_gnt), 32'h0);
        step();
        check_eq("s1_gnt1", 32'(wd_gnt), 32'h2);
        check_eq("s1_sel1", 32'(wd_sel), 32'h2);
        req = 3'b100;
        fin = 1'b1;
        step();
        fin = 1'b0;
        step();
        step();
        check_eq("s1_gnt2", 32'(wd_gnt), 32'h4);
        check_eq("s1_sel2", 32'(wd_sel), 32'h4);
        req = 3'b000;
        fin = 1'b1;
        step();
        fin = 1'b0;
        check_eq("s1_end_sel", 32'(wd_sel), 32'h4);
        step();
        step();

        // req1 alone, finish after 5 grant cycles, req1 kept high into GAP.
        req = 3'b010;
        step();
        check_eq("s2_rise", 32'(wd_gnt), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("s2_hold", 32'(wd_gnt), 32'h2);
        end
        fin = 1'b1;
        step();
        fin = 1'b0;
        check_eq("s2_rel_gnt",  32'(wd_gnt),  32'h0);
        check_eq("s2_rel_busy", 32'(wd_busy), 32'h0);
        step();
        check_eq("s2_gap_noarb", 32'(wd_gnt), 32'h0);
        req = 3'b000;
        step();
        check_eq("s2_idle_gnt", 32'(wd_gnt), 32'h0);
        check_eq("s2_sel_kept", 32'(wd_sel), 32'h2);

        // req0 and req2 held: grants alternate.
        req = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("s3_alt", 32'(wd_gnt), 32'(alt_exp[i]));
            fin = 1'b1;
            step();
            fin = 1'b0;
            check_eq("s3_rel", 32'(wd_gnt), 32'h0);
            step();
        end
        req = 3'b000;
        step();

        // Watchdog: req2 dropped after grant, no finish.
        req = 3'b100;
        step();
        check_eq("s4_wd_rise", 32'(wd_gnt), 32'h4);
        check_eq("s4_nw_rise", 32'(nw_gnt), 32'h4);
        req = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_eq("s4_hold", 32'(wd_gnt), 32'h4);
            check_eq("s4_no_to", 32'(wd_to), 32'h0);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("s4_exp_gnt",    32'(wd_gnt),    32'h0);
        check_eq("s4_exp_busy",   32'(wd_busy),   32'h0);
        check_eq("s4_exp_to",     32'(wd_to),     32'h1);
        check_eq("s4_exp_sticky", 32'(wd_sticky), 32'h1);
        check_eq("s4_exp_id",     32'(wd_id),     32'h2);
        check_eq("s4_exp_sel",    32'(wd_sel),    32'h4);
        check_eq("s4_nw_gnt",     32'(nw_gnt),    32'h4);
        check_eq("s4_nw_to",      32'(nw_to),     32'h0);
        check_eq("s4_nw_sticky",  32'(nw_sticky), 32'h0);
        step();
        check_eq("s4_to_once", 32'(wd_to),     32'h0);
        check_eq("s4_sticky",  32'(wd_sticky), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("s4_clr_sticky", 32'(wd_sticky), 32'h0);
        check_eq("s4_clr_id",     32'(wd_id),     32'h2);
        // Stray finish: ignored by the idle watchdog instance, releases the other.
        fin = 1'b1;
        step();
        fin = 1'b0;
        check_eq("s4_stray_gnt",  32'(wd_gnt),  32'h0);
        check_eq("s4_stray_busy", 32'(wd_busy), 32'h0);
        check_eq("s4_stray_sel",  32'(wd_sel),  32'h4);
        check_eq("s4_stray_to",   32'(wd_to),   32'h0);
        check_eq("s4_nw_rel",     32'(nw_gnt),  32'h0);
        check_eq("s4_nw_busy",    32'(nw_busy), 32'h0);
        step();
        step();

        // finish on the 8th grant cycle beats expiry.
        req = 3'b001;
        step();
        check_eq("s5_rise", 32'(wd_gnt), 32'h1);
        req = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_eq("s5_hold", 32'(wd_gnt), 32'h1);
        end
        fin = 1'b1;
        step();
        fin = 1'b0;
        check_eq("s5_rel_gnt", 32'(wd_gnt),    32'h0);
        check_eq("s5_no_to",   32'(wd_to),     32'h0);
        check_eq("s5_sticky",  32'(wd_sticky), 32'h0);
        step();
        check_eq("s5_gap_to", 32'(wd_to), 32'h0);
        step();

        // Reset mid-grant, then req1+req2.
        req = 3'b010;
        step();
        check_eq("s6_pre_gnt", 32'(wd_gnt), 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_gnt",  32'(wd_gnt),  32'h0);
        check_eq("s6_rst_sel",  32'(wd_sel),  32'h0);
        check_eq("s6_rst_busy", 32'(wd_busy), 32'h0);
        check_eq("s6_rst_id",   32'(wd_id),   32'h0);
        check_eq("s6_nw_gnt",   32'(nw_gnt),  32'h0);
        step();
        rst_n = 1'b1;
        req = 3'b110;
        step();
        check_eq("s6_post_gnt", 32'(wd_gnt), 32'h2);
        check_eq("s6_post_sel", 32'(wd_sel), 32'h2);
        check_eq("s6_nw_post",  32'(nw_gnt), 32'h2);
        req = 3'b000;
        fin = 1'b1;
        step();
        fin = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
